// File: rtl/park_pkg.sv
// Shared types, widths and fee helpers for the parking-lot controller.
// Optional overtime tracking in the top level is enabled by defining PARK_OVERTIME_EN.
package park_pkg;

    localparam int PARK_TIME_W = 10;

    typedef struct packed {
        logic                   occ;
        logic [PARK_TIME_W-1:0] stamp;
    } slot_t;

    // Slot index width; a single-slot lot still needs a 1-bit index.
    function automatic int slot_width(input int nSlots);
        return (nSlots <= 1) ? 1 : $clog2(nSlots);
    endfunction

    function automatic int cnt_width(input int nSlots);
        return $clog2(nSlots + 1);
    endfunction

    // Clamp a raw fee to the largest value representable in costW bits.
    function automatic logic [63:0] sat_fee(input logic [63:0] rawFee, input int costW);
        logic [63:0] maxFee;
        maxFee = (64'd1 << costW) - 64'd1;
        return (rawFee > maxFee) ? maxFee : rawFee;
    endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Request/response bundle between the lot sensors/board and the parking-lot controller.
// The overtime vector is only driven with real values when PARK_OVERTIME_EN is defined.
interface parking_lot_ctrl_if
    import park_pkg::*;
#(
    parameter int N_SLOTS = 3,
    parameter int TIME_W  = PARK_TIME_W,
    parameter int COST_W  = 10
);
    localparam int SLOT_W = slot_width(N_SLOTS);
    localparam int CNT_W  = cnt_width(N_SLOTS);

    logic               car_enter;
    logic               car_exit;
    logic [SLOT_W-1:0]  exit_slot;
    logic               enter_ack;
    logic               enter_rej;
    logic [SLOT_W-1:0]  ack_slot;
    logic               fee_valid;
    logic [COST_W-1:0]  fee;
    logic               exit_err;
    logic [CNT_W-1:0]   occupancy;
    logic               full_flag;
    logic               empty_flag;
    logic [TIME_W-1:0]  time_now;
    logic [N_SLOTS-1:0] overtime;

    modport master (
        output car_enter, car_exit, exit_slot,
        input  enter_ack, enter_rej, ack_slot, fee_valid, fee, exit_err,
               occupancy, full_flag, empty_flag, time_now, overtime
    );

    modport slave (
        input  car_enter, car_exit, exit_slot,
        output enter_ack, enter_rej, ack_slot, fee_valid, fee, exit_err,
               occupancy, full_flag, empty_flag, time_now, overtime
    );

endinterface

// File: rtl/park_tick_gen.sv
// Prescaler and wrapping time base: one tick every TICK_DIV clocks, time_now counts ticks.
module park_tick_gen #(
    parameter int TIME_W   = 10,
    parameter int TICK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              o_tick,
    output logic [TIME_W-1:0] o_time_now
);

    localparam int                 PRESC_W    = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0] r_presc;
    logic [TIME_W-1:0]  r_time;

    assign o_tick     = (r_presc == PRESC_LAST);
    assign o_time_now = r_time;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
            r_time  <= '0;
        end else if (o_tick) begin
            r_presc <= '0;
            r_time  <= r_time + TIME_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking-lot controller: lowest-free-slot allocation, entry timestamps, saturating exit fee,
// occupancy flags. Define PARK_OVERTIME_EN to build the per-slot overtime comparators.
module parking_lot_ctrl
    import park_pkg::*;
#(
    parameter int N_SLOTS  = 3,
    parameter int TIME_W   = PARK_TIME_W,
    parameter int COST_W   = 10,
    parameter int TICK_DIV = 4,
    parameter int RATE     = 5,
    parameter int BASE_FEE = 0,
    parameter int MAX_STAY = 100
) (
    input  logic                clk,
    input  logic                reset,
    parking_lot_ctrl_if.slave   bus
);

    localparam int               SLOT_W   = slot_width(N_SLOTS);
    localparam int               CNT_W    = cnt_width(N_SLOTS);
    localparam int               PROD_W   = TIME_W + COST_W;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_SLOTS);

    slot_t              r_table [N_SLOTS];
    logic               r_enter_ack;
    logic               r_enter_rej;
    logic [SLOT_W-1:0]  r_ack_slot;
    logic               r_fee_valid;
    logic [COST_W-1:0]  r_fee;
    logic               r_exit_err;
    logic [CNT_W-1:0]   r_occupancy;
    logic               r_full;
    logic               r_empty;

    logic               w_tick;
    logic               w_unused_tick;
    logic [TIME_W-1:0]  w_time_now;
    logic               w_free_found;
    logic [SLOT_W-1:0]  w_free_idx;
    logic               w_exit_occ;
    logic [TIME_W-1:0]  w_exit_stamp;
    logic               w_enter_ok;
    logic               w_exit_ok;
    logic [TIME_W-1:0]  w_elapsed;
    logic [PROD_W-1:0]  w_product;
    logic [63:0]        w_fee_raw;
    logic [COST_W-1:0]  w_fee;
    logic [CNT_W-1:0]   w_occ_next;

    park_tick_gen #(
        .TIME_W   (TIME_W),
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk        (clk),
        .reset      (reset),
        .o_tick     (w_tick),
        .o_time_now (w_time_now)
    );

    // Everything here works on time_now directly; the tick itself is not needed downstream.
    assign w_unused_tick = w_tick;

    // Priority allocator: scanning downwards leaves the lowest free index as the winner.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!r_table[i].occ) begin
                w_free_found = 1'b1;
                w_free_idx   = SLOT_W'(i);
            end
        end
    end

    // An out-of-range exit_slot matches no entry, so it reads as unoccupied and becomes an error.
    always_comb begin
        w_exit_occ   = 1'b0;
        w_exit_stamp = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (bus.exit_slot == SLOT_W'(i)) begin
                w_exit_occ   = r_table[i].occ;
                w_exit_stamp = r_table[i].stamp;
            end
        end
    end

    assign w_enter_ok = bus.car_enter && w_free_found;
    assign w_exit_ok  = bus.car_exit && w_exit_occ;

    assign w_elapsed  = w_time_now - w_exit_stamp;
    assign w_product  = PROD_W'(w_elapsed) * PROD_W'(RATE);
    assign w_fee_raw  = 64'(w_product) + 64'(BASE_FEE);
    assign w_fee      = COST_W'(sat_fee(w_fee_raw, COST_W));

    assign w_occ_next = r_occupancy + CNT_W'(w_enter_ok) - CNT_W'(w_exit_ok);

    // Slot table: entry and exit never target the same slot (free vs occupied).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (w_enter_ok && (w_free_idx == SLOT_W'(i))) begin
                    r_table[i].occ   <= 1'b1;
                    r_table[i].stamp <= w_time_now;
                end else if (w_exit_ok && (bus.exit_slot == SLOT_W'(i))) begin
                    r_table[i].occ   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_enter_ack <= 1'b0;
            r_enter_rej <= 1'b0;
            r_ack_slot  <= '0;
            r_fee_valid <= 1'b0;
            r_fee       <= '0;
            r_exit_err  <= 1'b0;
            r_occupancy <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
        end else begin
            r_enter_ack <= w_enter_ok;
            r_enter_rej <= bus.car_enter && !w_free_found;
            r_fee_valid <= w_exit_ok;
            r_exit_err  <= bus.car_exit && !w_exit_occ;
            if (w_enter_ok) begin
                r_ack_slot <= w_free_idx;
            end
            if (w_exit_ok) begin
                r_fee <= w_fee;
            end
            r_occupancy <= w_occ_next;
            r_full      <= (w_occ_next == CNT_FULL);
            r_empty     <= (w_occ_next == '0);
        end
    end

`ifdef PARK_OVERTIME_EN
    localparam logic [TIME_W:0] MAX_STAY_L = (TIME_W + 1)'(MAX_STAY);

    logic [N_SLOTS-1:0] r_overtime;

    // Extra top bit keeps MAX_STAY values beyond the time range from aliasing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overtime <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (w_exit_ok && (bus.exit_slot == SLOT_W'(i))) begin
                    r_overtime[i] <= 1'b0;
                end else begin
                    r_overtime[i] <= r_table[i].occ &&
                                     ({1'b0, w_time_now - r_table[i].stamp} >= MAX_STAY_L);
                end
            end
        end
    end

    assign bus.overtime = r_overtime;
`else
    assign bus.overtime = '0;
`endif

    assign bus.enter_ack  = r_enter_ack;
    assign bus.enter_rej  = r_enter_rej;
    assign bus.ack_slot   = r_ack_slot;
    assign bus.fee_valid  = r_fee_valid;
    assign bus.fee        = r_fee;
    assign bus.exit_err   = r_exit_err;
    assign bus.occupancy  = r_occupancy;
    assign bus.full_flag  = r_full;
    assign bus.empty_flag = r_empty;
    assign bus.time_now   = w_time_now;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench for parking_lot_ctrl (3 slots, 4-clock tick, rate 5); overtime checks
// follow PARK_OVERTIME_EN.
module tb_parking_lot_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   cyc;
    int   passCount  = 0;
    int   checkCount = 0;

    parking_lot_ctrl_if #(.N_SLOTS(3), .TIME_W(10), .COST_W(10)) bus ();

    parking_lot_ctrl #(
        .N_SLOTS  (3),
        .TIME_W   (10),
        .COST_W   (10),
        .TICK_DIV (4),
        .RATE     (5),
        .BASE_FEE (0),
        .MAX_STAY (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the next edge samples time_now == (cyc/4) mod 1024.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int modelTime();
        return (cyc / 4) % 1024;
    endfunction

    task automatic doReset();
        bus.car_enter = 1'b0;
        bus.car_exit  = 1'b0;
        bus.exit_slot = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one request cycle from a negedge; returns at the following negedge with results visible.
    task automatic cycleOp(input logic enter, input logic exitReq, input logic [1:0] slot);
        bus.car_enter = enter;
        bus.car_exit  = exitReq;
        bus.exit_slot = slot;
        @(posedge clk);
        @(negedge clk);
        bus.car_enter = 1'b0;
        bus.car_exit  = 1'b0;
        bus.exit_slot = '0;
    endtask

    task automatic waitTime(input int target, input string tag);
        int budget = 0;
        while (modelTime() != target && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        checkCount++;
        if (budget >= 20000) $display("[TB] FAIL %s_timeout: waited %0d cycles, required time %0d", tag, budget, target);
        else passCount++;
    endtask

    task automatic test_reset();
        bus.car_enter = 1'b0;
        bus.car_exit  = 1'b0;
        bus.exit_slot = '0;
        reset = 1'b1;
        @(negedge clk);
        checkCount++; if (bus.enter_ack !== 1'b0) $display("[TB] FAIL rst_ack: got %b want 0", bus.enter_ack); else passCount++;
        checkCount++; if (bus.enter_rej !== 1'b0) $display("[TB] FAIL rst_rej: got %b want 0", bus.enter_rej); else passCount++;
        checkCount++; if (bus.fee_valid !== 1'b0) $display("[TB] FAIL rst_fee_valid: got %b want 0", bus.fee_valid); else passCount++;
        checkCount++; if (bus.fee !== 10'd0) $display("[TB] FAIL rst_fee: got %0d want 0", bus.fee); else passCount++;
        checkCount++; if (bus.exit_err !== 1'b0) $display("[TB] FAIL rst_exit_err: got %b want 0", bus.exit_err); else passCount++;
        checkCount++; if (bus.occupancy !== 2'd0) $display("[TB] FAIL rst_occ: got %0d want 0", bus.occupancy); else passCount++;
        checkCount++; if (bus.full_flag !== 1'b0) $display("[TB] FAIL rst_full: got %b want 0", bus.full_flag); else passCount++;
        checkCount++; if (bus.empty_flag !== 1'b1) $display("[TB] FAIL rst_empty: got %b want 1", bus.empty_flag); else passCount++;
        checkCount++; if (bus.time_now !== 10'd0) $display("[TB] FAIL rst_time: got %0d want 0", bus.time_now); else passCount++;
        checkCount++; if (bus.overtime !== 3'b000) $display("[TB] FAIL rst_overtime: got %b want 000", bus.overtime); else passCount++;
        reset = 1'b0;
        repeat (9) @(negedge clk);
        checkCount++; if (bus.time_now !== 10'd2) $display("[TB] FAIL tick_time: got %0d want 2", bus.time_now); else passCount++;
    endtask

    task automatic test_fill();
        logic [1:0] expSlot [3] = '{2'd0, 2'd1, 2'd2};
        doReset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycleOp(1'b1, 1'b0, 2'd0);
            checkCount++; if (bus.enter_ack !== 1'b1) $display("[TB] FAIL fill_ack%0d: got %b want 1", i, bus.enter_ack); else passCount++;
            checkCount++; if (bus.ack_slot !== expSlot[i]) $display("[TB] FAIL fill_slot%0d: got %0d want %0d", i, bus.ack_slot, expSlot[i]); else passCount++;
            checkCount++; if (bus.occupancy !== 2'(i + 1)) $display("[TB] FAIL fill_occ%0d: got %0d want %0d", i, bus.occupancy, i + 1); else passCount++;
            @(negedge clk);
            checkCount++; if (bus.enter_ack !== 1'b0) $display("[TB] FAIL fill_pulse%0d: got %b want 0", i, bus.enter_ack); else passCount++;
        end
        checkCount++; if (bus.full_flag !== 1'b1) $display("[TB] FAIL fill_full: got %b want 1", bus.full_flag); else passCount++;
        checkCount++; if (bus.empty_flag !== 1'b0) $display("[TB] FAIL fill_empty: got %b want 0", bus.empty_flag); else passCount++;
        cycleOp(1'b1, 1'b0, 2'd0);
        checkCount++; if (bus.enter_rej !== 1'b1) $display("[TB] FAIL full_rej: got %b want 1", bus.enter_rej); else passCount++;
        checkCount++; if (bus.enter_ack !== 1'b0) $display("[TB] FAIL full_noack: got %b want 0", bus.enter_ack); else passCount++;
        checkCount++; if (bus.occupancy !== 2'd3) $display("[TB] FAIL full_occ: got %0d want 3", bus.occupancy); else passCount++;
    endtask

    task automatic test_fee();
        doReset();
        cycleOp(1'b1, 1'b0, 2'd0);
        checkCount++; if (bus.ack_slot !== 2'd0 || bus.enter_ack !== 1'b1) $display("[TB] FAIL fee_entry: got ack %b slot %0d want ack 1 slot 0", bus.enter_ack, bus.ack_slot); else passCount++;
        checkCount++; if (bus.empty_flag !== 1'b0) $display("[TB] FAIL fee_entry_empty: got %b want 0", bus.empty_flag); else passCount++;
        waitTime(12, "fee");
        cycleOp(1'b0, 1'b1, 2'd0);
        checkCount++; if (bus.fee_valid !== 1'b1) $display("[TB] FAIL fee_valid: got %b want 1", bus.fee_valid); else passCount++;
        checkCount++; if (bus.fee !== 10'd60) $display("[TB] FAIL fee_value: got %0d want 60", bus.fee); else passCount++;
        checkCount++; if (bus.occupancy !== 2'd0) $display("[TB] FAIL fee_occ: got %0d want 0", bus.occupancy); else passCount++;
        checkCount++; if (bus.empty_flag !== 1'b1) $display("[TB] FAIL fee_empty: got %b want 1", bus.empty_flag); else passCount++;
        @(negedge clk);
        checkCount++; if (bus.fee_valid !== 1'b0) $display("[TB] FAIL fee_pulse: got %b want 0", bus.fee_valid); else passCount++;
        checkCount++; if (bus.fee !== 10'd60) $display("[TB] FAIL fee_hold: got %0d want 60", bus.fee); else passCount++;
    endtask

    task automatic test_exit_err();
        logic [1:0] badSlot [2] = '{2'd1, 2'd3};
        for (int i = 0; i < 2; i++) begin
            cycleOp(1'b0, 1'b1, badSlot[i]);
            checkCount++; if (bus.exit_err !== 1'b1) $display("[TB] FAIL err_flag%0d: got %b want 1", i, bus.exit_err); else passCount++;
            checkCount++; if (bus.fee_valid !== 1'b0) $display("[TB] FAIL err_nofee%0d: got %b want 0", i, bus.fee_valid); else passCount++;
            checkCount++; if (bus.occupancy !== 2'd0 || bus.empty_flag !== 1'b1) $display("[TB] FAIL err_state%0d: got occ %0d empty %b want 0/1", i, bus.occupancy, bus.empty_flag); else passCount++;
            checkCount++; if (bus.fee !== 10'd60) $display("[TB] FAIL err_fee_hold%0d: got %0d want 60", i, bus.fee); else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int i = 0; i < 3; i++) begin
            cycleOp(1'b1, 1'b0, 2'd0);
            checkCount++; if (bus.ack_slot !== 2'(i)) $display("[TB] FAIL b2b_slot%0d: got %0d want %0d", i, bus.ack_slot, i); else passCount++;
        end
        waitTime(5, "simul");
        cycleOp(1'b1, 1'b1, 2'd1);
        checkCount++; if (bus.enter_rej !== 1'b1) $display("[TB] FAIL simul_rej: got %b want 1", bus.enter_rej); else passCount++;
        checkCount++; if (bus.enter_ack !== 1'b0) $display("[TB] FAIL simul_noack: got %b want 0", bus.enter_ack); else passCount++;
        checkCount++; if (bus.fee_valid !== 1'b1) $display("[TB] FAIL simul_fee_valid: got %b want 1", bus.fee_valid); else passCount++;
        checkCount++; if (bus.fee !== 10'd25) $display("[TB] FAIL simul_fee: got %0d want 25", bus.fee); else passCount++;
        checkCount++; if (bus.occupancy !== 2'd2 || bus.full_flag !== 1'b0) $display("[TB] FAIL simul_occ: got occ %0d full %b want 2/0", bus.occupancy, bus.full_flag); else passCount++;
        cycleOp(1'b1, 1'b0, 2'd0);
        checkCount++; if (bus.ack_slot !== 2'd1 || bus.enter_ack !== 1'b1) $display("[TB] FAIL refill_slot: got ack %b slot %0d want 1/1", bus.enter_ack, bus.ack_slot); else passCount++;
        checkCount++; if (bus.occupancy !== 2'd3 || bus.full_flag !== 1'b1) $display("[TB] FAIL refill_occ: got occ %0d full %b want 3/1", bus.occupancy, bus.full_flag); else passCount++;
    endtask

    task automatic test_wrap_saturate();
        int stampT;
        doReset();
        waitTime(1020, "wrap_enter");
        cycleOp(1'b1, 1'b0, 2'd0);
        waitTime(4, "wrap_exit");
        cycleOp(1'b0, 1'b1, 2'd0);
        checkCount++; if (bus.fee_valid !== 1'b1 || bus.fee !== 10'd40) $display("[TB] FAIL wrap_fee: got valid %b fee %0d want 1/40", bus.fee_valid, bus.fee); else passCount++;
        stampT = modelTime();
        cycleOp(1'b1, 1'b0, 2'd0);
        waitTime((stampT + 300) % 1024, "sat");
        cycleOp(1'b0, 1'b1, 2'd0);
        checkCount++; if (bus.fee_valid !== 1'b1 || bus.fee !== 10'd1023) $display("[TB] FAIL sat_fee: got valid %b fee %0d want 1/1023", bus.fee_valid, bus.fee); else passCount++;
    endtask

    task automatic test_overtime_reset_mid();
        doReset();
        cycleOp(1'b1, 1'b0, 2'd0);
        cycleOp(1'b1, 1'b0, 2'd0);
        waitTime(98, "ot_early");
        checkCount++; if (bus.overtime !== 3'b000) $display("[TB] FAIL ot_early: got %b want 000", bus.overtime); else passCount++;
        waitTime(101, "ot_late");
`ifdef PARK_OVERTIME_EN
        checkCount++; if (bus.overtime !== 3'b011) $display("[TB] FAIL ot_set: got %b want 011", bus.overtime); else passCount++;
        cycleOp(1'b0, 1'b1, 2'd0);
        checkCount++; if (bus.fee !== 10'd505) $display("[TB] FAIL ot_fee: got %0d want 505", bus.fee); else passCount++;
        @(negedge clk);
        checkCount++; if (bus.overtime !== 3'b010) $display("[TB] FAIL ot_clear: got %b want 010", bus.overtime); else passCount++;
`else
        checkCount++; if (bus.overtime !== 3'b000) $display("[TB] FAIL ot_tied: got %b want 000", bus.overtime); else passCount++;
`endif
        reset = 1'b1;
        #1;
        checkCount++; if (bus.occupancy !== 2'd0 || bus.empty_flag !== 1'b1) $display("[TB] FAIL mid_rst_occ: got occ %0d empty %b want 0/1", bus.occupancy, bus.empty_flag); else passCount++;
        checkCount++; if (bus.overtime !== 3'b000) $display("[TB] FAIL mid_rst_ot: got %b want 000", bus.overtime); else passCount++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkCount++; if (bus.fee_valid !== 1'b0) $display("[TB] FAIL mid_rst_nofee: got %b want 0", bus.fee_valid); else passCount++;
        cycleOp(1'b1, 1'b0, 2'd0);
        checkCount++; if (bus.ack_slot !== 2'd0 || bus.occupancy !== 2'd1) $display("[TB] FAIL mid_rst_reuse: got slot %0d occ %0d want 0/1", bus.ack_slot, bus.occupancy); else passCount++;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_fill();
        test_fee();
        test_exit_err();
        test_back_to_back();
        test_wrap_saturate();
        test_overtime_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
